// File: rtl/lc3b_mem_responder.sv
// LC-3b split instruction/data memory responder: one 16-bit array, data-port priority, fixed latency.
// Optional MEM_ADDR_CHECK_EN adds out-of-range detection (reads 16'hDEAD, writes dropped, sticky addr_fault).
module lc3b_mem_responder #(
    parameter int    DEPTH_LOG2 = 10,
    parameter int    LATENCY    = 3,
    parameter string INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instruction_request,
    input  logic [15:0] instruction_address,
    output logic [15:0] instr,
    output logic        instruction_response,
    input  logic        data_request,
    input  logic        write_enable,
    input  logic [15:0] mem_address,
    input  logic [15:0] write_data,
    output logic [15:0] mem_rdata,
`ifdef MEM_ADDR_CHECK_EN
    output logic        data_response,
    output logic        addr_fault
`else
    output logic        data_response
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int         WORDS       = 1 << DEPTH_LOG2;
    localparam logic [3:0] COUNT_LOAD  = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam state_t     FIRST_STATE = (LATENCY > 1) ? ST_WAIT : ST_RESP;

`ifdef MEM_ADDR_CHECK_EN
    // Any address bit above the array's word index marks the access as out of range
    function automatic logic addr_out_of_range(input logic [15:0] addr);
        addr_out_of_range = (addr >> (DEPTH_LOG2 + 1)) != 16'd0;
    endfunction
`endif

    logic [15:0]           mem_r [WORDS];
    state_t                state_r;
    logic [3:0]            count_r;
    logic                  grant_data_r;
    logic                  write_r;
    logic                  oor_r;
    logic [DEPTH_LOG2-1:0] word_addr_r;
    logic [15:0]           wdata_r;
    logic [15:0]           sel_addr_s;
    logic [15:0]           rd_word_s;
    logic                  oor_s;
    logic                  mem_wr_s;
    logic                  unused_s;

    // Byte bit 0 (and, without the check, the upper bits) never select a word
    assign unused_s = ^{instruction_address, mem_address};

    // Port selection, range check and read-word formation
    always_comb begin
        sel_addr_s = instruction_address;
        rd_word_s  = mem_r[word_addr_r];
        oor_s      = 1'b0;
        if (data_request) begin
            sel_addr_s = mem_address;
        end else begin
            sel_addr_s = instruction_address;
        end
`ifdef MEM_ADDR_CHECK_EN
        oor_s = addr_out_of_range(sel_addr_s);
        if (oor_r) begin
            rd_word_s = 16'hDEAD;
        end else begin
            rd_word_s = mem_r[word_addr_r];
        end
`endif
        mem_wr_s = (state_r == ST_RESP) && grant_data_r && write_r && !oor_r;
    end

    // Access sequencer; responses are registered on the edge leaving RESP,
    // so the pulse is visible while the FSM is already back in IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r              <= ST_IDLE;
            count_r              <= 4'd0;
            grant_data_r         <= 1'b0;
            write_r              <= 1'b0;
            oor_r                <= 1'b0;
            word_addr_r          <= '0;
            wdata_r              <= 16'h0000;
            instr                <= 16'h0000;
            mem_rdata            <= 16'h0000;
            instruction_response <= 1'b0;
            data_response        <= 1'b0;
`ifdef MEM_ADDR_CHECK_EN
            addr_fault           <= 1'b0;
`endif
        end else begin
            instruction_response <= 1'b0;
            data_response        <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (data_request || instruction_request) begin
                        grant_data_r <= data_request;
                        write_r      <= data_request & write_enable;
                        wdata_r      <= write_data;
                        word_addr_r  <= sel_addr_s[DEPTH_LOG2:1];
                        oor_r        <= oor_s;
                        count_r      <= COUNT_LOAD;
                        state_r      <= FIRST_STATE;
                    end
                end
                ST_WAIT: begin
                    if (count_r == 4'd0) begin
                        state_r <= ST_RESP;
                    end else begin
                        count_r <= count_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                    if (grant_data_r) begin
                        data_response <= 1'b1;
                        if (!write_r) begin
                            mem_rdata <= rd_word_s;
                        end
                    end else begin
                        instruction_response <= 1'b1;
                        instr                <= rd_word_s;
                    end
`ifdef MEM_ADDR_CHECK_EN
                    if (oor_r) begin
                        addr_fault <= 1'b1;
                    end
`endif
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Backing array write port; deliberately not reset so contents survive reset
    always_ff @(posedge clk) begin
        if (mem_wr_s) begin
            mem_r[word_addr_r] <= wdata_r;
        end
    end

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Bench for lc3b_mem_responder: directed scenarios plus random two-port traffic against an edge-count model.
module tb_lc3b_mem_responder;

    localparam int LAT = 3;
`ifdef MEM_ADDR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        ireq, dreq, we, iresp, dresp;
    logic [15:0] iaddr, daddr, wdata, instr, rdata;
    logic        l1_ireq, l1_dreq, l1_we, l1_iresp, l1_dresp;
    logic [15:0] l1_iaddr, l1_daddr, l1_wdata, l1_instr, l1_rdata;
`ifdef MEM_ADDR_CHECK_EN
    logic        fault;
    logic        l1_fault;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    lc3b_mem_responder #(.DEPTH_LOG2(10), .LATENCY(LAT)) dut (
        .clk                  (clk),
        .reset                (reset),
        .instruction_request  (ireq),
        .instruction_address  (iaddr),
        .instr                (instr),
        .instruction_response (iresp),
        .data_request         (dreq),
        .write_enable         (we),
        .mem_address          (daddr),
        .write_data           (wdata),
        .mem_rdata            (rdata),
        .data_response        (dresp)
`ifdef MEM_ADDR_CHECK_EN
       ,.addr_fault           (fault)
`endif
    );

    lc3b_mem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut1 (
        .clk                  (clk),
        .reset                (reset),
        .instruction_request  (l1_ireq),
        .instruction_address  (l1_iaddr),
        .instr                (l1_instr),
        .instruction_response (l1_iresp),
        .data_request         (l1_dreq),
        .write_enable         (l1_we),
        .mem_address          (l1_daddr),
        .write_data           (l1_wdata),
        .mem_rdata            (l1_rdata),
        .data_response        (l1_dresp)
`ifdef MEM_ADDR_CHECK_EN
       ,.addr_fault           (l1_fault)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Reference model: an access accepted at edge a responds at edge a+LAT; the port is free again at a+LAT+1
    logic [15:0] mdl_mem [0:1023];
    bit          mdl_known [0:1023];
    bit          mdl_busy = 1'b0;
    int          mdl_edge = 0;
    int          mdl_resp_edge = 0;
    int          mdl_idx = 0;
    bit          mdl_gd, mdl_we, mdl_oor;
    logic [15:0] mdl_wd, mdl_a;
    logic        exp_iresp, exp_dresp, exp_fault;
    logic [15:0] exp_instr, exp_rdata;
    bit          exp_instr_known, exp_rdata_known;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mdl_busy = 1'b0;
            exp_iresp = 1'b0; exp_dresp = 1'b0; exp_fault = 1'b0;
            exp_instr = 16'h0000; exp_rdata = 16'h0000;
            exp_instr_known = 1'b1; exp_rdata_known = 1'b1;
        end else begin
            exp_iresp = 1'b0;
            exp_dresp = 1'b0;
            if (mdl_busy && mdl_edge == mdl_resp_edge) begin
                if (mdl_gd) begin
                    exp_dresp = 1'b1;
                    if (mdl_we) begin
                        if (!mdl_oor) begin
                            mdl_mem[mdl_idx]   = mdl_wd;
                            mdl_known[mdl_idx] = 1'b1;
                        end
                    end else begin
                        exp_rdata       = mdl_oor ? 16'hDEAD : mdl_mem[mdl_idx];
                        exp_rdata_known = mdl_oor || mdl_known[mdl_idx];
                    end
                end else begin
                    exp_iresp       = 1'b1;
                    exp_instr       = mdl_oor ? 16'hDEAD : mdl_mem[mdl_idx];
                    exp_instr_known = mdl_oor || mdl_known[mdl_idx];
                end
                if (mdl_oor) exp_fault = 1'b1;
            end else if (!mdl_busy || mdl_edge > mdl_resp_edge) begin
                mdl_busy = 1'b0;
                if (dreq || ireq) begin
                    mdl_busy      = 1'b1;
                    mdl_resp_edge = mdl_edge + LAT;
                    mdl_gd        = dreq;
                    mdl_a         = dreq ? daddr : iaddr;
                    mdl_idx       = int'(mdl_a[10:1]);
                    mdl_we        = dreq && we;
                    mdl_wd        = wdata;
                    mdl_oor       = CHECK_EN && (mdl_a[15:11] != 5'd0);
                end
            end
            mdl_edge++;
        end
    end

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // One cycle: wait for the falling edge and compare the main DUT against the model
    task automatic tick();
        @(negedge clk);
        cyc++;
        check_val("iresp", 16'(iresp), 16'(exp_iresp));
        check_val("dresp", 16'(dresp), 16'(exp_dresp));
        if (exp_instr_known) check_val("instr", instr, exp_instr);
        if (exp_rdata_known) check_val("rdata", rdata, exp_rdata);
`ifdef MEM_ADDR_CHECK_EN
        check_val("fault", 16'(fault), 16'(exp_fault));
`endif
    endtask

    task automatic access(input bit is_d, input bit wr, input logic [15:0] addr,
                          input logic [15:0] wd, output int lat);
        int start;
        if (is_d) begin
            dreq = 1'b1; we = wr; daddr = addr; wdata = wd;
        end else begin
            ireq = 1'b1; iaddr = addr;
        end
        start = cyc;
        lat   = -1;
        for (int k = 0; k < 20 && lat < 0; k++) begin
            tick();
            if (is_d && dresp) begin lat = cyc - start - 1; dreq = 1'b0; end
            if (!is_d && iresp) begin lat = cyc - start - 1; ireq = 1'b0; end
        end
        dreq = 1'b0;
        ireq = 1'b0;
        check_val("resp_seen", 16'(lat >= 0), 16'd1);
    endtask

    function automatic logic [15:0] rand_addr();
        logic [15:0] a;
        a = {10'd0, 5'($urandom_range(0, 31)), 1'($urandom)};
        if ($urandom_range(0, 7) == 0) a[15:11] = 5'($urandom);
        return a;
    endfunction

    initial begin
        int lat, start, dl, il;
        bit got;
        reset = 1'b1;
        ireq = 1'b0; dreq = 1'b0; we = 1'b0;
        iaddr = 16'h0000; daddr = 16'h0000; wdata = 16'h0000;
        l1_ireq = 1'b0; l1_dreq = 1'b0; l1_we = 1'b0;
        l1_iaddr = 16'h0000; l1_daddr = 16'h0000; l1_wdata = 16'h0000;
        repeat (3) @(negedge clk);
        check_val("rst_instr", instr, 16'h0000);
        check_val("rst_rdata", rdata, 16'h0000);
        check_val("rst_resp", 16'({iresp, dresp}), 16'd0);
        reset = 1'b0;
        repeat (2) tick();

        for (int i = 0; i < 32; i++) access(1'b1, 1'b1, 16'(i * 2), 16'hA000 + 16'(i), lat);

        // Fetch latency and data
        access(1'b1, 1'b1, 16'h0004, 16'h1234, lat);
        access(1'b0, 1'b0, 16'h0004, 16'h0000, lat);
        check_val("t1_lat", 16'(lat), 16'd3);
        check_val("t1_instr", instr, 16'h1234);

        // Write then read back, including the odd byte address
        access(1'b1, 1'b1, 16'h0010, 16'hBEEF, lat);
        check_val("t2_wr_lat", 16'(lat), 16'd3);
        access(1'b1, 1'b0, 16'h0010, 16'h0000, lat);
        check_val("t2_rd", rdata, 16'hBEEF);
        access(1'b1, 1'b0, 16'h0011, 16'h0000, lat);
        check_val("t2_rd_odd", rdata, 16'hBEEF);

        // Simultaneous requests: data first, fetch LAT+1 later
        ireq = 1'b1; iaddr = 16'h0000;
        dreq = 1'b1; we = 1'b0; daddr = 16'h0002;
        start = cyc; dl = -1; il = -1;
        for (int k = 0; k < 30 && (ireq || dreq); k++) begin
            tick();
            if (dresp) begin dl = cyc - start - 1; dreq = 1'b0; end
            if (iresp) begin il = cyc - start - 1; ireq = 1'b0; end
        end
        ireq = 1'b0; dreq = 1'b0;
        check_val("t3_d_lat", 16'(dl), 16'd3);
        check_val("t3_i_lat", 16'(il), 16'd7);
        check_val("t3_rdata", rdata, 16'hA001);
        check_val("t3_instr", instr, 16'hA000);

        // Reset during WAIT aborts a write
        dreq = 1'b1; we = 1'b1; daddr = 16'h0020; wdata = 16'h5555;
        tick();
        tick();
        reset = 1'b1; dreq = 1'b0; we = 1'b0;
        #1;
        check_val("t4_instr", instr, 16'h0000);
        check_val("t4_rdata", rdata, 16'h0000);
        check_val("t4_resp", 16'({iresp, dresp}), 16'd0);
        tick();
        reset = 1'b0;
        repeat (4) tick();
        access(1'b1, 1'b0, 16'h0020, 16'h0000, lat);
        check_val("t4_word", rdata, 16'hA010);

        // Address beyond the array
        access(1'b1, 1'b0, 16'h0800, 16'h0000, lat);
`ifdef MEM_ADDR_CHECK_EN
        check_val("t6_dead", rdata, 16'hDEAD);
        check_val("t6_fault", 16'(fault), 16'd1);
        repeat (3) tick();
        check_val("t6_sticky", 16'(fault), 16'd1);
`else
        check_val("t6_wrap", rdata, 16'hA000);
`endif

        // Random two-port traffic, including held (re-issued) requests and inputs changing after acceptance
        for (int c = 0; c < 2500; c++) begin
            tick();
            if (dresp && $urandom_range(0, 3) != 0) dreq = 1'b0;
            if (iresp && $urandom_range(0, 3) != 0) ireq = 1'b0;
            if (mdl_busy && mdl_gd && dreq && !dresp && $urandom_range(0, 3) == 0) begin
                daddr = 16'($urandom); wdata = 16'($urandom); we = 1'($urandom);
            end
            if (mdl_busy && !mdl_gd && ireq && !iresp && $urandom_range(0, 3) == 0) begin
                iaddr = 16'($urandom);
            end
            if (!dreq && $urandom_range(0, 2) == 0) begin
                dreq = 1'b1; we = 1'($urandom); daddr = rand_addr(); wdata = 16'($urandom);
            end
            if (!ireq && $urandom_range(0, 2) == 0) begin
                ireq = 1'b1; iaddr = rand_addr();
            end
        end
        ireq = 1'b0; dreq = 1'b0;
        repeat (10) tick();

        // LATENCY=1 instance: held fetch responds every second cycle, instr holds between pulses
        l1_dreq = 1'b1; l1_we = 1'b1; l1_daddr = 16'h0006; l1_wdata = 16'hA5A5;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            tick();
            if (l1_dresp) got = 1'b1;
        end
        l1_dreq = 1'b0; l1_we = 1'b0;
        check_val("l1_wr_done", 16'(got), 16'd1);
        l1_ireq = 1'b1; l1_iaddr = 16'h0006;
        for (int t = 1; t <= 10; t++) begin
            tick();
            check_val("l1_resp", 16'(l1_iresp), (t % 2 == 0) ? 16'd1 : 16'd0);
            check_val("l1_instr", l1_instr, (t >= 2) ? 16'hA5A5 : 16'h0000);
        end
        l1_ireq = 1'b0;
`ifdef MEM_ADDR_CHECK_EN
        check_val("l1_fault", 16'(l1_fault), 16'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
